// File: rtl/animation_sequencer.sv
// Frame sequencer for the 7-segment animation display.
// Owns the current animation index, counts frames 0..limit-1 at a programmable
// rate, queues animation change requests until the next frame boundary and can
// auto-advance to the next animation after a fixed number of complete loops.
module animation_sequencer #(
  parameter int unsigned BASE_DIV = 1000000,  // clock cycles per base tick (>= 2)
  parameter int unsigned LOOPS    = 3,        // complete cycles before auto-advance (>= 1)
  parameter int unsigned MAX_ANI  = 50        // highest valid animation index
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] speed,
  input  logic       auto,
  input  logic [5:0] ani_req,
  input  logic       ani_load,
  input  logic [5:0] limit,
  output logic [5:0] animation,
  output logic [5:0] frame,
  output logic       frame_tick,
  output logic       wrap,
  output logic       pending
);

  localparam int unsigned DivW  = (BASE_DIV > 2) ? $clog2(BASE_DIV) : 1;
  localparam int unsigned LoopW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [DivW-1:0]  DivMax  = DivW'(BASE_DIV - 1);
  localparam logic [LoopW-1:0] LoopMax = LoopW'(LOOPS - 1);
  localparam logic [5:0]       MaxAni  = 6'(MAX_ANI);

  // State registers
  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [3:0]       sub_cnt_q, sub_cnt_d;
  logic [LoopW-1:0] loop_cnt_q, loop_cnt_d;
  logic [5:0]       req_q, req_d;
  logic [5:0]       animation_q, animation_d;
  logic [5:0]       frame_q, frame_d;
  logic             frame_tick_q, frame_tick_d;
  logic             wrap_q, wrap_d;
  logic             pending_q, pending_d;

  // Decoded timing events
  logic       base_tick;
  logic       boundary;
  logic [5:0] lim_eff;
  logic       last_frame;
  logic       req_ok;

  // Prescaler and speed counter: a boundary is a base tick with sub_cnt >= speed,
  // so lowering speed mid-frame fires at the next base tick instead of stalling.
  always_comb begin
    base_tick = enable && (div_cnt_q == DivMax);
    boundary  = base_tick && (sub_cnt_q >= speed);

    div_cnt_d = div_cnt_q;
    if (enable) begin
      div_cnt_d = base_tick ? '0 : div_cnt_q + DivW'(1);
    end

    sub_cnt_d = sub_cnt_q;
    if (base_tick) begin
      sub_cnt_d = boundary ? 4'd0 : sub_cnt_q + 4'd1;
    end
  end

  // Effective frame limit; an empty table entry behaves as a single frame.
  always_comb begin
    lim_eff    = (limit == 6'd0) ? 6'd1 : limit;
    // >= lets frame recover to 0 if the limit shrinks underneath it.
    last_frame = frame_q >= (lim_eff - 6'd1);
    req_ok     = ani_load && (ani_req <= MaxAni);
  end

  // Frame/animation/loop update at a boundary, then request latching.
  always_comb begin
    animation_d  = animation_q;
    frame_d      = frame_q;
    loop_cnt_d   = loop_cnt_q;
    req_d        = req_q;
    pending_d    = pending_q;
    frame_tick_d = 1'b0;
    wrap_d       = 1'b0;

    if (boundary) begin
      frame_tick_d = 1'b1;
      if (pending_q) begin
        // Queued request takes priority over wrap and auto-advance.
        animation_d = req_q;
        frame_d     = 6'd0;
        loop_cnt_d  = '0;
        pending_d   = 1'b0;
      end else if (last_frame) begin
        frame_d = 6'd0;
        wrap_d  = 1'b1;
        if (auto && (loop_cnt_q == LoopMax)) begin
          animation_d = (animation_q == MaxAni) ? 6'd0 : animation_q + 6'd1;
          loop_cnt_d  = '0;
        end else if (loop_cnt_q != LoopMax) begin
          loop_cnt_d = loop_cnt_q + LoopW'(1);
        end
      end else begin
        frame_d = frame_q + 6'd1;
      end
    end

    // Evaluated after the boundary so a load in a boundary cycle waits for the
    // following boundary; the boundary above always used the old req_q.
    if (req_ok) begin
      req_d     = ani_req;
      pending_d = 1'b1;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      sub_cnt_q    <= 4'd0;
      loop_cnt_q   <= '0;
      req_q        <= 6'd0;
      animation_q  <= 6'd0;
      frame_q      <= 6'd0;
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      loop_cnt_q   <= loop_cnt_d;
      req_q        <= req_d;
      animation_q  <= animation_d;
      frame_q      <= frame_d;
      frame_tick_q <= frame_tick_d;
      wrap_q       <= wrap_d;
      pending_q    <= pending_d;
    end
  end

  assign animation  = animation_q;
  assign frame      = frame_q;
  assign frame_tick = frame_tick_q;
  assign wrap       = wrap_q;
  assign pending    = pending_q;

endmodule
